// File: rtl/result_argmax_reader.sv
// result_argmax_reader
//
// Drains the accelerator's result vector out of the neuron RAM after a rising
// edge of acc_finished, streams each word over a valid/ready port and keeps a
// running signed argmax that becomes the classification output.
//
// Ports:
//   clk, reset           clock (rising edge) and synchronous active-low reset
//   acc_finished         accelerator finished level; a rising edge starts a drain
//   result_base_address  first result word address (sampled at latch only)
//   result_word_count    number of result words (sampled at latch only)
//   ram_rd_adr           registered neuron RAM read address
//   ram_rd_data          neuron RAM read data, RD_LATENCY cycles after the address
//   out_valid/out_ready  stream handshake
//   out_data             result word
//   out_index            word offset from base (0-based)
//   out_last             marks the final word
//   busy                 high from latch until the drain completes
//   argmax_valid         argmax outputs valid (held in DONE)
//   argmax_index         offset of the maximum word (ties keep the lower index)
//   argmax_value         maximum value, signed
module result_argmax_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_finished,
  input  logic [ADDR_W-1:0] result_base_address,
  input  logic [ADDR_W-1:0] result_word_count,
  output logic [ADDR_W-1:0] ram_rd_adr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              argmax_valid,
  output logic [ADDR_W-1:0] argmax_index,
  output logic [DATA_W-1:0] argmax_value
);

  localparam int WC_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic              fin_q;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] idx;
  logic [WC_W-1:0]   wait_cnt;

  logic rise;
  logic wait_last;
  logic handshake;
  logic better;

  assign rise      = acc_finished & ~fin_q;
  assign wait_last = (wait_cnt == WC_LAST);
  assign handshake = out_valid & out_ready;
  // The first word always seeds the maximum; afterwards only a strictly
  // greater signed value replaces it, so ties keep the lower index.
  assign better    = (idx == '0) || ($signed(ram_rd_data) > $signed(argmax_value));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (rise) state_next = (result_word_count == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_last) state_next = S_OUT;
      S_OUT:   if (handshake) state_next = out_last ? S_DONE : S_ISSUE;
      S_DONE:  if (!acc_finished) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // fin_q resets high so a level already high at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fin_q        <= 1'b1;
      base         <= '0;
      count        <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      ram_rd_adr   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      argmax_valid <= 1'b0;
      argmax_index <= '0;
      argmax_value <= '0;
    end else begin
      fin_q <= acc_finished;
      case (state)
        S_IDLE: begin
          if (rise) begin
            base  <= result_base_address;
            count <= result_word_count;
            idx   <= '0;
            busy  <= 1'b1;
            if (result_word_count == '0) begin
              argmax_index <= '0;
              argmax_value <= '0;
            end
          end
        end
        S_ISSUE: begin
          // Address arithmetic wraps modulo the RAM size.
          ram_rd_adr <= base + idx;
          wait_cnt   <= '0;
        end
        S_WAIT: begin
          if (wait_last) begin
            out_data  <= ram_rd_data;
            out_index <= idx;
            out_last  <= (idx == count - 1'b1);
            out_valid <= 1'b1;
            if (better) begin
              argmax_value <= ram_rd_data;
              argmax_index <= idx;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy         <= 1'b0;
              argmax_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          busy         <= 1'b0;
          argmax_valid <= acc_finished;
        end
        default: ;
      endcase
    end
  end

endmodule
